target_sequencer: RTL

- Game controller for the reflex trainer. Sequences the on-screen target through a fixed number of rounds.
- Each round: place the 40x40 ball at a pseudo-random position, time the player's reaction to a hit, score it, then blank the ball for an inter-round gap.
- Drives the ball-position and ball-enable inputs of the ball display logic. Reports score, misses, last reaction time and game-over to the HUD/seven-segment logic.

---
 rtl/target_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/target_sequencer.sv
// ---------------------------------------------------------------------------
// target_sequencer
// Game controller for the reflex trainer. Runs a game of ROUNDS targets:
// each round spawns a 40x40 ball at a pseudo-random position, times the
// player's reaction until a hit (or a timeout miss), then hides the ball for
// an inter-round gap. Results go to the HUD / seven-segment logic.
//
// Ports:
//   clk        in   25 MHz pixel clock
//   rst_n      in   asynchronous active-low reset
//   start_btn  in   single-cycle start pulse (debounced upstream)
//   hit        in   single-cycle pulse, pointer click landed on the ball
//   start      out  game active (SPAWN / ACTIVE / GAP)
//   ballX      out  [9:0] target left edge in pixels
//   ballY      out  [9:0] target top edge in pixels
//   ball_on    out  ball visible (ACTIVE)
//   score      out  [7:0] hits this game
//   misses     out  [7:0] timeouts this game
//   react_ms   out  [9:0] reaction time of the most recent hit in ms
//   round_idx  out  [7:0] current round, 0-based
//   game_over  out  high in DONE
// ---------------------------------------------------------------------------
module target_sequencer #(
    parameter int          CLK_PER_MS = 25000,
    parameter int          TIMEOUT_MS = 1000,
    parameter int          GAP_MS     = 500,
    parameter int          ROUNDS     = 20,
    parameter int          BALL_SIZE  = 40,
    parameter int          H_MAX      = 640,
    parameter int          V_MAX      = 480,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_btn,
    input  logic       hit,
    output logic       start,
    output logic [9:0] ballX,
    output logic [9:0] ballY,
    output logic       ball_on,
    output logic [7:0] score,
    output logic [7:0] misses,
    output logic [9:0] react_ms,
    output logic [7:0] round_idx,
    output logic       game_over
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SPAWN  = 3'd1;
    localparam logic [2:0] S_ACTIVE = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

    localparam logic [9:0] X_SPAN = 10'(H_MAX - BALL_SIZE);
    localparam logic [9:0] Y_SPAN = 10'(V_MAX - BALL_SIZE);

    logic [2:0]    r_state;
    logic [15:0]   r_lfsr;
    logic [PW-1:0] r_presc;
    logic [9:0]    r_msCnt;
    logic [9:0]    r_ballX;
    logic [9:0]    r_ballY;
    logic [7:0]    r_score;
    logic [7:0]    r_misses;
    logic [9:0]    r_react;
    logic [7:0]    r_round;

    logic [2:0]    w_nextState;
    logic          w_stateChange;
    logic          w_tick;
    logic          w_timeout;
    logic          w_gapDone;
    logic          w_newGame;
    logic [7:0]    w_roundNext;
    logic [9:0]    w_xr;
    logic [9:0]    w_yr;
    logic [9:0]    w_spawnX;
    logic [9:0]    w_spawnY;

    assign w_tick      = (r_presc == PW'(CLK_PER_MS - 1));
    assign w_roundNext = r_round + 8'd1;
    assign w_newGame   = ((r_state == S_IDLE) || (r_state == S_DONE)) && start_btn;

    // Timeout and gap end fire on the tick that carries the ms counter up to
    // its limit, so a target is visible for exactly TIMEOUT_MS full ms and a
    // hit on that same cycle still reads TIMEOUT_MS-1 completed ms.
    assign w_timeout = (r_state == S_ACTIVE) && w_tick && (r_msCnt == 10'(TIMEOUT_MS - 1));
    assign w_gapDone = (r_state == S_GAP) && w_tick && (r_msCnt == 10'(GAP_MS - 1));

    // Folding the raw LFSR bits into the visible area with a single
    // subtraction is enough because the raw range is less than twice the span.
    assign w_xr     = r_lfsr[9:0];
    assign w_yr     = {1'b0, r_lfsr[15:7]};
    assign w_spawnX = (w_xr >= X_SPAN) ? (w_xr - X_SPAN) : w_xr;
    assign w_spawnY = (w_yr >= Y_SPAN) ? (w_yr - Y_SPAN) : w_yr;

    // Next-state decode; a hit takes priority over a coincident timeout.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:   if (start_btn) w_nextState = S_SPAWN;
            S_SPAWN:  w_nextState = S_ACTIVE;
            S_ACTIVE: if (hit || w_timeout) w_nextState = S_GAP;
            S_GAP:    if (w_gapDone) w_nextState = (w_roundNext == 8'(ROUNDS)) ? S_DONE : S_SPAWN;
            S_DONE:   if (start_btn) w_nextState = S_SPAWN;
            default:  w_nextState = S_IDLE;
        endcase
    end

    assign w_stateChange = (w_nextState != r_state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Free-running Galois LFSR; it steps every cycle so the player's timing
    // decides which value is sampled at the next spawn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= r_lfsr[0] ? ({1'b0, r_lfsr[15:1]} ^ 16'hB400) : {1'b0, r_lfsr[15:1]};
        end
    end

    // Prescaler and ms counter restart on every state entry so each state
    // starts with a full first millisecond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_msCnt <= '0;
        end else if (w_stateChange) begin
            r_presc <= '0;
            r_msCnt <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_msCnt <= r_msCnt + 10'd1;
            end
        end
    end

    // Game bookkeeping: position latch, score/miss counting, round advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ballX  <= '0;
            r_ballY  <= '0;
            r_score  <= '0;
            r_misses <= '0;
            r_react  <= '0;
            r_round  <= '0;
        end else begin
            if (w_newGame) begin
                r_score  <= '0;
                r_misses <= '0;
                r_react  <= '0;
                r_round  <= '0;
            end
            if (r_state == S_SPAWN) begin
                r_ballX <= w_spawnX;
                r_ballY <= w_spawnY;
            end
            if (r_state == S_ACTIVE) begin
                if (hit) begin
                    r_score <= r_score + 8'd1;
                    r_react <= r_msCnt;
                end else if (w_timeout) begin
                    r_misses <= r_misses + 8'd1;
                end
            end
            if (w_gapDone) begin
                r_round <= w_roundNext;
            end
        end
    end

    assign start     = (r_state == S_SPAWN) || (r_state == S_ACTIVE) || (r_state == S_GAP);
    assign ball_on   = (r_state == S_ACTIVE);
    assign game_over = (r_state == S_DONE);
    assign ballX     = r_ballX;
    assign ballY     = r_ballY;
    assign score     = r_score;
    assign misses    = r_misses;
    assign react_ms  = r_react;
    assign round_idx = r_round;

endmodule
